// File: rtl/mult_sweep_ctrl_if.sv
// Operand/product handshake between the sweep sequencer and the multiplier under test.
interface mult_sweep_ctrl_if #(
  parameter int W = 5
);
  logic                  mul_req;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic                  mul_ack;
  logic signed [2*W-1:0] mul_prod;

  modport master (output mul_req, mul_a, mul_b, input mul_ack, mul_prod);
  modport slave  (input mul_req, mul_a, mul_b, output mul_ack, mul_prod);
endinterface

// File: rtl/mult_sweep_ctrl.sv
// Exhaustive A-outer/B-inner operand sweep of a shared signed multiplier with
// per-pair product checking, saturating pair/error counts and handshake timeout.
module mult_sweep_ctrl #(
  parameter int W       = 5,
  parameter int LO      = -7,
  parameter int HI      = 7,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  mult_sweep_ctrl_if.master     mul,
  output logic                  res_valid,
  output logic signed [W-1:0]   res_a,
  output logic signed [W-1:0]   res_b,
  output logic signed [2*W-1:0] res_prod,
  output logic                  res_err,
  output logic [7:0]            err_cnt,
  output logic [7:0]            pair_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
  localparam logic signed [W-1:0] LO_V = W'(LO);
  localparam logic signed [W-1:0] HI_V = W'(HI);
  localparam logic signed [W-1:0] ONE  = W'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  state_t                state, state_n;
  logic                  req, req_n;
  logic signed [W-1:0]   a, a_n, b, b_n;
  logic [CW-1:0]         wait_cnt, wait_n;
  logic                  rv_n, re_n, busy_n, done_n, to_n;
  logic signed [W-1:0]   ra_n, rb_n;
  logic signed [2*W-1:0] rp_n, ref_prod;
  logic [7:0]            ec_n, pc_n;

  assign mul.mul_req = req;
  assign mul.mul_a   = a;
  assign mul.mul_b   = b;

  // Reference product: both operands sign-extended to 2W, so the product is exact.
  always_comb begin
    ref_prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_n = state;
    req_n   = req;
    a_n     = a;
    b_n     = b;
    wait_n  = wait_cnt;
    rv_n    = 1'b0;
    re_n    = 1'b0;
    ra_n    = res_a;
    rb_n    = res_b;
    rp_n    = res_prod;
    ec_n    = err_cnt;
    pc_n    = pair_cnt;
    to_n    = timeout;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_n     = LO_V;
          b_n     = LO_V;
          req_n   = 1'b1;
          wait_n  = '0;
          ec_n    = '0;
          pc_n    = '0;
          to_n    = 1'b0;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        // ack takes priority over a timeout expiring on the same cycle
        if (mul.mul_ack) begin
          ra_n    = a;
          rb_n    = b;
          rp_n    = mul.mul_prod;
          rv_n    = 1'b1;
          re_n    = (mul.mul_prod != ref_prod);
          if (pair_cnt != '1) pc_n = pair_cnt + 8'd1;
          if (re_n && err_cnt != '1) ec_n = err_cnt + 8'd1;
          req_n   = 1'b0;
          state_n = S_GAP;
        end else if (wait_cnt == LAST_WAIT) begin
          req_n   = 1'b0;
          to_n    = 1'b1;
          state_n = S_DONE;
        end else begin
          wait_n  = wait_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (a == HI_V && b == HI_V) begin
          state_n = S_DONE;
        end else if (!pause) begin
          if (b == HI_V) begin
            b_n = LO_V;
            a_n = a + ONE;
          end else begin
            b_n = b + ONE;
          end
          req_n   = 1'b1;
          wait_n  = '0;
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_REQ) || (state_n == S_GAP);
    done_n = (state_n == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req       <= 1'b0;
      a         <= '0;
      b         <= '0;
      wait_cnt  <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      res_prod  <= '0;
      err_cnt   <= '0;
      pair_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      req       <= req_n;
      a         <= a_n;
      b         <= b_n;
      wait_cnt  <= wait_n;
      res_valid <= rv_n;
      res_err   <= re_n;
      res_a     <= ra_n;
      res_b     <= rb_n;
      res_prod  <= rp_n;
      err_cnt   <= ec_n;
      pair_cnt  <= pc_n;
      busy      <= busy_n;
      done      <= done_n;
      timeout   <= to_n;
    end
  end
endmodule

// File: tb/tb_mult_sweep_ctrl.sv
// Bench for mult_sweep_ctrl: random-latency multiplier responder, sweep-order
// reference model and directed scenario sequence.
module tb_mult_sweep_ctrl;
  localparam int N = 15;

  logic              clk, rst, start, pause;
  logic              res_valid, res_err, busy, done, timeout;
  logic signed [4:0] res_a, res_b;
  logic signed [9:0] res_prod;
  logic [7:0]        err_cnt, pair_cnt;

  mult_sweep_ctrl_if #(.W(5)) mul ();

  mult_sweep_ctrl #(.W(5), .LO(-7), .HI(7), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mul(mul),
    .res_valid(res_valid), .res_a(res_a), .res_b(res_b), .res_prod(res_prod),
    .res_err(res_err), .err_cnt(err_cnt), .pair_cnt(pair_cnt),
    .busy(busy), .done(done), .timeout(timeout)
  );

  int n_vec = 0, n_err = 0;
  int sweep_id = 0;
  bit corrupt = 0, noack = 0, spur = 0;
  int n_rv, n_rerr, first_prod, m7_7_prod, last_a, last_b, last_prod;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog obs=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_prod(input int a, input int b);
    if (corrupt && a == -3 && b == 5) return 0;
    return a * b;
  endfunction

  // Multiplier responder: random 0..3 cycle ack delay, optional corruption,
  // optional silence, optional spurious acks while no request is pending.
  initial begin
    int cnt, lat;
    cnt = 0; lat = 0;
    mul.mul_ack = 0; mul.mul_prod = '0;
    forever begin
      @(negedge clk);
      if (mul.mul_ack) begin
        mul.mul_ack = 0;
        cnt = 0;
        lat = $urandom_range(0, 3);
      end else if (mul.mul_req && !noack) begin
        if (cnt >= lat) begin
          mul.mul_ack  = 1;
          mul.mul_prod = 10'(model_prod(int'(mul.mul_a), int'(mul.mul_b)));
        end else cnt++;
      end else if (!mul.mul_req) begin
        cnt = 0;
        if (spur) begin
          mul.mul_ack  = 1;
          mul.mul_prod = 10'($urandom);
        end
      end
    end
  end

  // Result monitor: k-th result of a sweep must be pair (LO + k/N, LO + k%N).
  initial begin
    int idx, last_id, ea, eb, ep;
    idx = 0; last_id = 0;
    forever begin
      @(negedge clk);
      if (sweep_id != last_id) begin
        last_id = sweep_id; idx = 0; n_rv = 0; n_rerr = 0;
      end
      if (res_valid) begin
        ea = -7 + idx / N;
        eb = -7 + idx % N;
        ep = model_prod(ea, eb);
        check("res_a", res_a, ea);
        check("res_b", res_b, eb);
        check("res_prod", res_prod, ep);
        check("res_err", res_err, (ep != ea * eb) ? 1 : 0);
        if (idx == 0) first_prod = res_prod;
        if (res_a == -7 && res_b == 7) m7_7_prod = res_prod;
        last_a = res_a; last_b = res_b; last_prod = res_prod;
        n_rv++;
        if (res_err) n_rerr++;
        idx++;
      end
    end
  end

  task automatic pulse_start();
    sweep_id++;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int t = 0;
    while (!done && t < bound) begin
      @(negedge clk);
      t++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_res(input string tag, input int a, input int b, input int bound);
    int t = 0;
    while (!(res_valid && res_a == a && res_b == b) && t < bound) begin
      @(negedge clk);
      t++;
    end
    check(tag, (res_valid && res_a == a && res_b == b) ? 1 : 0, 1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_req"}, mul.mul_req, 0);
    check({pfx, "_a"}, mul.mul_a, 0);
    check({pfx, "_b"}, mul.mul_b, 0);
    check({pfx, "_rv"}, res_valid, 0);
    check({pfx, "_res_a"}, res_a, 0);
    check({pfx, "_res_b"}, res_b, 0);
    check({pfx, "_res_prod"}, res_prod, 0);
    check({pfx, "_res_err"}, res_err, 0);
    check({pfx, "_err_cnt"}, err_cnt, 0);
    check({pfx, "_pair_cnt"}, pair_cnt, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_timeout"}, timeout, 0);
  endtask

  initial begin
    int hi_cycles;
    rst = 1; start = 0; pause = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(negedge clk);

    // correct multiplier, full sweep
    pulse_start();
    check("first_req", mul.mul_req, 1);
    check("first_a", mul.mul_a, -7);
    check("first_b", mul.mul_b, -7);
    wait_done("sweep1_done", 5000);
    check("sweep1_nrv", n_rv, 225);
    check("sweep1_first_prod", first_prod, 49);
    check("sweep1_m7_7_prod", m7_7_prod, -49);
    check("sweep1_last_a", last_a, 7);
    check("sweep1_last_b", last_b, 7);
    check("sweep1_last_prod", last_prod, 49);
    check("sweep1_err_cnt", err_cnt, 0);
    check("sweep1_pair_cnt", pair_cnt, 225);
    check("sweep1_timeout", timeout, 0);

    // corrupted product for (-3,5)
    corrupt = 1;
    pulse_start();
    wait_done("sweep2_done", 5000);
    check("sweep2_nrerr", n_rerr, 1);
    check("sweep2_err_cnt", err_cnt, 1);
    check("sweep2_pair_cnt", pair_cnt, 225);
    corrupt = 0;

    // multiplier never acks
    noack = 1;
    pulse_start();
    hi_cycles = 0;
    while (mul.mul_req && hi_cycles < 40) begin
      hi_cycles++;
      @(negedge clk);
    end
    check("to_req_cycles", hi_cycles, 15);
    check("to_req_low", mul.mul_req, 0);
    check("to_timeout", timeout, 1);
    check("to_done", done, 1);
    check("to_pair_cnt", pair_cnt, 0);
    check("to_nrv", n_rv, 0);
    noack = 0;
    @(negedge clk);

    // pause for 10 cycles after the third result
    pulse_start();
    check("restart_timeout_clr", timeout, 0);
    wait_res("pause_third", -7, -5, 100);
    pause = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_req", mul.mul_req, 0);
      check("pause_a", mul.mul_a, -7);
      check("pause_b", mul.mul_b, -5);
    end
    pause = 0;
    @(negedge clk);
    check("unpause_req", mul.mul_req, 1);
    check("unpause_a", mul.mul_a, -7);
    check("unpause_b", mul.mul_b, -4);
    wait_done("pause_done", 5000);
    check("pause_pair_cnt", pair_cnt, 225);

    // reset in the middle of pair (0,2)
    pulse_start();
    begin
      int t = 0;
      while (!(mul.mul_req && mul.mul_a == 0 && mul.mul_b == 2) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("mid_found", (mul.mul_req && mul.mul_a == 0 && mul.mul_b == 2) ? 1 : 0, 1);
    end
    rst = 1;
    @(negedge clk);
    check_zero("midrst");
    rst = 0;
    @(negedge clk);
    pulse_start();
    check("rs_req", mul.mul_req, 1);
    check("rs_a", mul.mul_a, -7);
    check("rs_b", mul.mul_b, -7);

    // start while busy plus spurious acks in a paused gap
    wait_res("busy_second", -7, -6, 100);
    pause = 1; start = 1; spur = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy_a", mul.mul_a, -7);
      check("busy_b", mul.mul_b, -6);
      check("busy_pair_cnt", pair_cnt, 2);
      check("busy_err_cnt", err_cnt, 0);
      check("busy_rv", res_valid, 0);
      check("busy_busy", busy, 1);
    end
    start = 0; spur = 0;
    repeat (2) @(negedge clk);
    pause = 0;
    wait_done("busy_done", 5000);
    check("busy_final_pair_cnt", pair_cnt, 225);
    check("busy_final_err_cnt", err_cnt, 0);
    check("busy_final_nrv", n_rv, 225);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
